// File: rtl/issue_queue.sv
// issue_queue: collapsing out-of-order issue queue with
// operand wakeup, priority/age select and branch kill.
module issue_queue #(
  parameter int         DEPTH     = 8,
  parameter int         WIDTH_BRM = 6,
  parameter logic [1:0] QTYPE     = 2'b10
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [4:0]           i_ctrl,
  input  logic [6:0]           i_uop,
  input  logic [14:0]          i_regs,
  input  logic [9:0]           i_func,
  input  logic [31:0]          i_imm,
  input  logic [WIDTH_BRM-1:0] i_brmask,
  input  logic                 i_rs1_rdy,
  input  logic                 i_rs2_rdy,
  output logic                 o_full,
  input  logic                 i_wk_en,
  input  logic [4:0]           i_wk_tag,
  input  logic                 i_kill_en,
  input  logic [WIDTH_BRM-1:0] i_kill_tag,
  output logic                 o_iss_valid,
  input  logic                 i_iss_ready,
  output logic [6:0]           o_iss_uop,
  output logic [14:0]          o_iss_regs,
  output logic [9:0]           o_iss_func,
  output logic [31:0]          o_iss_imm,
  output logic [WIDTH_BRM-1:0] o_iss_brmask,
  output logic [1:0]           o_iss_pry
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [WIDTH_BRM-1:0] HALF = 1 << (WIDTH_BRM - 1);

  logic [6:0]           uop_q  [DEPTH];
  logic [14:0]          regs_q [DEPTH];
  logic [9:0]           func_q [DEPTH];
  logic [31:0]          imm_q  [DEPTH];
  logic [WIDTH_BRM-1:0] brm_q  [DEPTH];
  logic [1:0]           pry_q  [DEPTH];
  logic [6:0]           uop_d  [DEPTH];
  logic [14:0]          regs_d [DEPTH];
  logic [9:0]           func_d [DEPTH];
  logic [31:0]          imm_d  [DEPTH];
  logic [WIDTH_BRM-1:0] brm_d  [DEPTH];
  logic [1:0]           pry_d  [DEPTH];
  logic [DEPTH-1:0]     r1_q, r2_q, r1_d, r2_d;
  logic [CW-1:0]        count_q, count_d;

  logic [DEPTH-1:0] vld, cand, wk1, wk2, young;
  logic [IW-1:0]    sel, hi_idx, lo_idx;
  logic             hi_hit, fire, accept;
  logic [CW-1:0]    wpos, kill_idx;
  logic [4:0]       in_rs1, in_rs2;
  logic             in_r1, in_r2;

  // per-entry valid, post-wakeup ready, candidacy, kill match
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld[i]   = CW'(i) < count_q;
      wk1[i]   = r1_q[i] | (i_wk_en && i_wk_tag != 5'd0 &&
                            regs_q[i][4:0] == i_wk_tag);
      wk2[i]   = r2_q[i] | (i_wk_en && i_wk_tag != 5'd0 &&
                            regs_q[i][9:5] == i_wk_tag);
      cand[i]  = vld[i] & r1_q[i] & r2_q[i];
      young[i] = vld[i] &&
                 (WIDTH_BRM'(brm_q[i] - i_kill_tag) < HALF);
    end
  end

  // lowest-index high-priority / any candidate, first killed slot
  always_comb begin
    hi_hit   = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    kill_idx = count_q;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_idx = IW'(i);
        if (pry_q[i] == 2'b11) begin
          hi_hit = 1'b1;
          hi_idx = IW'(i);
        end
      end
      if (young[i]) kill_idx = CW'(i);
    end
  end

  assign sel         = hi_hit ? hi_idx : lo_idx;
  assign o_full      = count_q == CW'(DEPTH);
  assign o_iss_valid = (|cand) & ~i_kill_en;
  assign fire        = o_iss_valid & i_iss_ready;
  assign accept      = i_ctrl[0] && i_ctrl[2:1] == QTYPE &&
                       !o_full && !i_kill_en;
  assign wpos        = count_q - {{(CW-1){1'b0}}, fire};
  assign in_rs1      = i_regs[4:0];
  assign in_rs2      = i_regs[9:5];
  assign in_r1       = i_rs1_rdy || in_rs1 == 5'd0 ||
                       (i_wk_en && i_wk_tag == in_rs1);
  assign in_r2       = i_rs2_rdy || in_rs2 == 5'd0 ||
                       (i_wk_en && i_wk_tag == in_rs2);

  assign o_iss_uop    = o_iss_valid ? uop_q[sel]  : '0;
  assign o_iss_regs   = o_iss_valid ? regs_q[sel] : '0;
  assign o_iss_func   = o_iss_valid ? func_q[sel] : '0;
  assign o_iss_imm    = o_iss_valid ? imm_q[sel]  : '0;
  assign o_iss_brmask = o_iss_valid ? brm_q[sel]  : '0;
  assign o_iss_pry    = o_iss_valid ? pry_q[sel]  : '0;

  // occupancy: kill truncates, otherwise add dispatch, drop issue
  always_comb begin
    if (i_kill_en)
      count_d = kill_idx;
    else
      count_d = count_q + {{(CW-1){1'b0}}, accept}
                        - {{(CW-1){1'b0}}, fire};
  end

  // entry next-state: wakeup, collapse above issued slot, dispatch
  always_comb begin
    r1_d = wk1;
    r2_d = wk2;
    for (int i = 0; i < DEPTH; i++) begin
      uop_d[i]  = uop_q[i];
      regs_d[i] = regs_q[i];
      func_d[i] = func_q[i];
      imm_d[i]  = imm_q[i];
      brm_d[i]  = brm_q[i];
      pry_d[i]  = pry_q[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (fire && IW'(i) >= sel) begin
        uop_d[i]  = uop_q[i+1];
        regs_d[i] = regs_q[i+1];
        func_d[i] = func_q[i+1];
        imm_d[i]  = imm_q[i+1];
        brm_d[i]  = brm_q[i+1];
        pry_d[i]  = pry_q[i+1];
        r1_d[i]   = wk1[i+1];
        r2_d[i]   = wk2[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && CW'(i) == wpos) begin
        uop_d[i]  = i_uop;
        regs_d[i] = i_regs;
        func_d[i] = i_func;
        imm_d[i]  = i_imm;
        brm_d[i]  = i_brmask;
        pry_d[i]  = i_ctrl[4:3];
        r1_d[i]   = in_r1;
        r2_d[i]   = in_r2;
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        uop_q[i]  <= '0;
        regs_q[i] <= '0;
        func_q[i] <= '0;
        imm_q[i]  <= '0;
        brm_q[i]  <= '0;
        pry_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      for (int i = 0; i < DEPTH; i++) begin
        uop_q[i]  <= uop_d[i];
        regs_q[i] <= regs_d[i];
        func_q[i] <= func_d[i];
        imm_q[i]  <= imm_d[i];
        brm_q[i]  <= brm_d[i];
        pry_q[i]  <= pry_d[i];
      end
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed and random stimulus against a
// queue-based reference model of the issue queue.
module tb_issue_queue;
  localparam int DEPTH = 8;

  logic        i_clk, i_rst_n;
  logic [4:0]  i_ctrl;
  logic [6:0]  i_uop;
  logic [14:0] i_regs;
  logic [9:0]  i_func;
  logic [31:0] i_imm;
  logic [5:0]  i_brmask;
  logic        i_rs1_rdy, i_rs2_rdy;
  logic        o_full;
  logic        i_wk_en;
  logic [4:0]  i_wk_tag;
  logic        i_kill_en;
  logic [5:0]  i_kill_tag;
  logic        o_iss_valid;
  logic        i_iss_ready;
  logic [6:0]  o_iss_uop;
  logic [14:0] o_iss_regs;
  logic [9:0]  o_iss_func;
  logic [31:0] o_iss_imm;
  logic [5:0]  o_iss_brmask;
  logic [1:0]  o_iss_pry;

  issue_queue #(.DEPTH(8), .WIDTH_BRM(6), .QTYPE(2'b10)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ctrl(i_ctrl),
    .i_uop(i_uop), .i_regs(i_regs), .i_func(i_func),
    .i_imm(i_imm), .i_brmask(i_brmask),
    .i_rs1_rdy(i_rs1_rdy), .i_rs2_rdy(i_rs2_rdy),
    .o_full(o_full), .i_wk_en(i_wk_en), .i_wk_tag(i_wk_tag),
    .i_kill_en(i_kill_en), .i_kill_tag(i_kill_tag),
    .o_iss_valid(o_iss_valid), .i_iss_ready(i_iss_ready),
    .o_iss_uop(o_iss_uop), .o_iss_regs(o_iss_regs),
    .o_iss_func(o_iss_func), .o_iss_imm(o_iss_imm),
    .o_iss_brmask(o_iss_brmask), .o_iss_pry(o_iss_pry)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [6:0]  uop;
    logic [14:0] regs;
    logic [9:0]  func;
    logic [31:0] imm;
    logic [5:0]  brm;
    logic [1:0]  pry;
    bit          r1;
    bit          r2;
  } ent_t;

  ent_t       mq[$];
  int         checks = 0;
  int         errors = 0;
  logic [5:0] cur_tag;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit younger(input logic [5:0] b,
                                 input logic [5:0] t);
    logic [5:0] d;
    d = b - t;
    return d < 6'd32;
  endfunction

  function automatic int pick();
    int lo = -1;
    foreach (mq[k]) begin
      if (mq[k].r1 && mq[k].r2) begin
        if (mq[k].pry == 2'b11) return k;
        if (lo < 0) lo = k;
      end
    end
    return lo;
  endfunction

  task automatic idle();
    i_ctrl = '0; i_uop = '0; i_regs = '0; i_func = '0;
    i_imm = '0; i_brmask = '0; i_rs1_rdy = 0; i_rs2_rdy = 0;
    i_wk_en = 0; i_wk_tag = '0; i_kill_en = 0; i_kill_tag = '0;
  endtask

  task automatic disp(input logic [1:0] pry, input logic [1:0] qc,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit rd1, input bit rd2,
                      input logic [5:0] brm, input logic [6:0] uop);
    i_ctrl = {pry, qc, 1'b1};
    i_regs = {5'($urandom), rs2, rs1};
    i_uop = uop;
    i_func = 10'($urandom);
    i_imm = $urandom;
    i_brmask = brm;
    i_rs1_rdy = rd1;
    i_rs2_rdy = rd2;
  endtask

  // compare outputs with the model, then advance model and clock
  task automatic step();
    int s;
    bit iv, fire, acc, full;
    ent_t n;
    logic [127:0] pkt;
    #1;
    s = pick();
    full = mq.size() == DEPTH;
    iv = (s >= 0) && !i_kill_en;
    pkt = '0;
    if (iv)
      pkt = {mq[s].uop, mq[s].regs, mq[s].func, mq[s].imm,
             mq[s].brm, mq[s].pry};
    check("full", o_full, full);
    check("iss_valid", o_iss_valid, iv);
    check("iss_pkt", {o_iss_uop, o_iss_regs, o_iss_func,
                      o_iss_imm, o_iss_brmask, o_iss_pry}, pkt);
    fire = iv && i_iss_ready;
    acc = i_ctrl[0] && i_ctrl[2:1] == 2'b10 && !full && !i_kill_en;
    if (i_wk_en && i_wk_tag != 5'd0) begin
      foreach (mq[k]) begin
        if (mq[k].regs[4:0] == i_wk_tag) mq[k].r1 = 1;
        if (mq[k].regs[9:5] == i_wk_tag) mq[k].r2 = 1;
      end
    end
    if (i_kill_en) begin
      for (int k = 0; k < mq.size(); k++) begin
        if (younger(mq[k].brm, i_kill_tag)) begin
          while (mq.size() > k) void'(mq.pop_back());
          break;
        end
      end
    end else begin
      if (fire) mq.delete(s);
      if (acc) begin
        n.uop = i_uop; n.regs = i_regs; n.func = i_func;
        n.imm = i_imm; n.brm = i_brmask; n.pry = i_ctrl[4:3];
        n.r1 = i_rs1_rdy || i_regs[4:0] == 5'd0 ||
               (i_wk_en && i_wk_tag == i_regs[4:0]);
        n.r2 = i_rs2_rdy || i_regs[9:5] == 5'd0 ||
               (i_wk_en && i_wk_tag == i_regs[9:5]);
        mq.push_back(n);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    check("rst_valid", o_iss_valid, 0);
    check("rst_full", o_full, 0);
    check("rst_pkt", {o_iss_uop, o_iss_regs, o_iss_func,
                      o_iss_imm, o_iss_brmask, o_iss_pry}, 0);
    mq.delete();
    #1 i_rst_n = 1'b1;
  endtask

  task automatic drain();
    idle();
    i_iss_ready = 1;
    for (int k = 0; k < 20 && mq.size() > 0; k++) step();
    check("drained", mq.size(), 0);
  endtask

  initial begin
    logic [5:0] span;
    i_rst_n = 1'b1;
    idle();
    i_iss_ready = 0;
    cur_tag = 6'd50;
    @(posedge i_clk);
    #1;
    do_reset();

    // basic flow
    i_iss_ready = 1;
    disp(2'b00, 2'b10, 5'd3, 5'd4, 1, 1, 6'd1, 7'h11);
    step();
    idle();
    #1 check("basic_valid", o_iss_valid, 1);
    check("basic_uop", o_iss_uop, 7'h11);
    step();
    check("basic_empty", o_iss_valid, 0);

    // foreign queue code is ignored
    disp(2'b00, 2'b01, 5'd0, 5'd0, 1, 1, 6'd1, 7'h22);
    step();
    idle();
    #1 check("mem_ignored", o_iss_valid, 0);

    // fill, overflow attempt, full-with-issue
    i_iss_ready = 0;
    for (int k = 0; k < 8; k++) begin
      disp(2'b00, 2'b10, 5'd9, 5'd0, 0, 0, 6'd2, 7'(k));
      step();
    end
    idle();
    #1 check("full_set", o_full, 1);
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd2, 7'h77);
    step();
    idle();
    i_wk_en = 1;
    i_wk_tag = 5'd9;
    step();
    idle();
    i_iss_ready = 1;
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd2, 7'h55);
    #1 check("fulliss_valid", o_iss_valid, 1);
    check("fulliss_full", o_full, 1);
    step();
    idle();
    #1 check("full_freed", o_full, 0);
    drain();

    // wakeup: tag 0 wakes nothing, tag 5 wakes next cycle
    disp(2'b00, 2'b10, 5'd5, 5'd0, 0, 0, 6'd3, 7'h31);
    step();
    idle();
    i_wk_en = 1;
    i_wk_tag = 5'd0;
    step();
    idle();
    #1 check("wk0_none", o_iss_valid, 0);
    i_wk_en = 1;
    i_wk_tag = 5'd5;
    step();
    idle();
    #1 check("wk5_issue", o_iss_valid, 1);
    check("wk5_uop", o_iss_uop, 7'h31);
    step();
    disp(2'b00, 2'b10, 5'd6, 5'd0, 0, 0, 6'd3, 7'h32);
    i_wk_en = 1;
    i_wk_tag = 5'd6;
    step();
    idle();
    #1 check("wk_disp", o_iss_valid, 1);
    step();

    // priority then age
    i_iss_ready = 0;
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd4, 7'h41); step();
    disp(2'b11, 2'b10, 5'd0, 5'd0, 1, 1, 6'd4, 7'h42); step();
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd4, 7'h43); step();
    idle();
    i_iss_ready = 1;
    #1 check("pri_first", o_iss_uop, 7'h42);
    step();
    check("pri_second", o_iss_uop, 7'h41);
    step();
    check("pri_third", o_iss_uop, 7'h43);
    step();

    // kill with tags 3,4,4,5 at tag 4
    i_iss_ready = 0;
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd3, 7'h51); step();
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd4, 7'h52); step();
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd4, 7'h53); step();
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd5, 7'h54); step();
    idle();
    i_iss_ready = 1;
    i_kill_en = 1;
    i_kill_tag = 6'd4;
    #1 check("kill_block", o_iss_valid, 0);
    step();
    idle();
    #1 check("kill_surv", o_iss_uop, 7'h51);
    step();
    check("kill_empty", o_iss_valid, 0);

    // kill across tag wrap
    i_iss_ready = 0;
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd62, 7'h61); step();
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd63, 7'h62); step();
    disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd0, 7'h63); step();
    idle();
    i_kill_en = 1;
    i_kill_tag = 6'd63;
    step();
    idle();
    i_iss_ready = 1;
    #1 check("wrap_surv", o_iss_uop, 7'h61);
    step();
    check("wrap_empty", o_iss_valid, 0);

    // async reset with four entries resident
    i_iss_ready = 0;
    for (int k = 0; k < 4; k++) begin
      disp(2'b00, 2'b10, 5'd0, 5'd0, 1, 1, 6'd7, 7'(8'h70 + k));
      step();
    end
    idle();
    do_reset();
    i_iss_ready = 1;
    step();
    check("rst_no_iss", o_iss_valid, 0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      i_iss_ready = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 9) < 6) begin
        span = (mq.size() > 0) ? 6'(cur_tag + 6'd1 - mq[0].brm)
                               : 6'd0;
        if ($urandom_range(0, 1) == 1 && span < 6'd16)
          cur_tag = cur_tag + 6'd1;
        disp(2'($urandom),
             ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             cur_tag, 7'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        i_wk_en = 1;
        i_wk_tag = 5'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 19) == 0) begin
        i_kill_en = 1;
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          i_kill_tag = mq[$urandom_range(0, mq.size() - 1)].brm;
        else
          i_kill_tag = 6'(cur_tag + 6'd1);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
# issue_queue

In-order-allocated, out-of-order-issue queue that receives dispatch packets from `decode` and holds them until their source operands are ready. It then issues one micro-op per cycle to its functional unit. It consumes the `decode` packet fields as produced: the ctrl word {pry, queue, valid}, the regs word {rd, rs2, rs1}, func, imm, uop and brmask. It also discards wrong-path entries when a branch misprediction kill arrives. One instance exists per queue type (ALU, MEM).

## Interface
- `DEPTH`, 8: number of entries (power of two, ≥2).
- `WIDTH_BRM`, 6: branch-tag width; must match `decode`.
- `QTYPE`, 2'b10: queue code this instance accepts (2'b10 = ALU, 2'b01 = MEM).

- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_ctrl`  in  5  {pry[1:0], queue[1:0], valid}.
- `i_uop`  in  7  opcode.
- `i_regs`  in  15  {rd, rs2, rs1}; a field of 0 means unused/x0.
- `i_func`  in  10  {funct7, funct3}.
- `i_imm`  in  32  immediate.
- `i_brmask`  in  WIDTH_BRM  branch tag.
- `i_rs1_rdy`, `i_rs2_rdy`  in  1 each  source already available at dispatch.
- `o_full`  out  1  no free entry.
- `i_wk_en`  in  1  wakeup broadcast valid.
- `i_wk_tag`  in  5  destination register being written back.
- `i_kill_en`  in  1  mispredict kill.
- `i_kill_tag`  in  WIDTH_BRM  oldest branch tag to discard.
- `o_iss_valid`  out  1  issue packet valid.
- `i_iss_ready`  in  1  functional unit accepts.
- `o_iss_uop` (7), `o_iss_regs` (15), `o_iss_func` (10), `o_iss_imm` (32), `o_iss_brmask` (WIDTH_BRM), `o_iss_pry` (2)  out  issue packet fields.

## Operation
- **Storage.** Collapsing array `e[0..DEPTH-1]` with `count` (width log2(DEPTH)+1).
  - Entry 0 is the oldest; entries 0..count-1 are valid.
  - Each entry holds: uop, regs, func, imm, brmask, pry, r1, r2.
- **Dispatch accept.** Condition: `i_ctrl[0]` && `i_ctrl[2:1]`==QTYPE && !`o_full` && !`i_kill_en`. Packets with any other queue code are ignored silently.
- **Initial ready bits.**
  - r1 = `i_rs1_rdy` || rs1==0 || (`i_wk_en` && `i_wk_tag`==rs1 && rs1!=0).
  - r2 is computed the same way from rs2.
- **Wakeup.** Each edge, every valid entry with rsN==`i_wk_tag` (nonzero) and `i_wk_en` sets rN. A tag of 0 wakes nothing.
- **Select** (combinational from registered state).
  - Candidates: valid entries with r1 && r2.
  - Choice: the lowest-index candidate with pry==2'b11. If there is none, the lowest-index candidate.
  - `o_iss_valid` = candidate exists && !`i_kill_en`. The issue fields are that entry's fields.
  - When `o_iss_valid` is 0, the issue fields are don't-care; they are driven to 0.
- **Issue.** Fires when `o_iss_valid` && `i_iss_ready`.
  - The issued entry is removed; entries above it shift down one slot, preserving order.
- **Write position.** Dispatch writes at slot `count`, or `count`-1 when an issue fires in the same cycle.
- **Kill.** An entry is younger-or-equal when d = (brmask − `i_kill_tag`) mod 2^WIDTH_BRM has MSB 0.
  - Program order makes these entries a suffix of the array.
  - On kill, `count` becomes the index of the first such entry, or is unchanged if none match.
  - Kill blocks both issue and dispatch that cycle.
  - Wakeups still apply to surviving entries.
- **Counter update.**
  - `count_next` = `count` + dispatch − issue when there is no kill.
  - `count` never exceeds DEPTH and never underflows.
- **`o_full`** = (`count`==DEPTH), registered-state based. There is no credit for a same-cycle issue.

## Timing
- **Reset** (asynchronous, `i_rst_n`=0):
  - `count`=0, all r1/r2=0, `o_full`=0, `o_iss_valid`=0, issue fields 0.
  - Reset asserted mid-operation drops all entries immediately.
- **Latency.** Dispatch at edge N makes the entry issueable in cycle N+1 if ready. Minimum dispatch-to-issue latency is 1 cycle.
- **Wakeup timing.** A wakeup in cycle N makes the entry selectable in cycle N+1; wakeup does not bypass combinationally into select.
- **Issue stall.** While `i_iss_ready`=0, the packet shown may change only through wakeups or new dispatches into a higher-priority position. Nothing is removed.
- **Full with issue.** At full, a cycle with an issue plus a dispatch attempt rejects the dispatch; the slot becomes free the following cycle.
- **Wrap-around.** The brmask comparison is modular. Tags of entries resident at the same time must span fewer than 2^(WIDTH_BRM−1) values.

## Test plan
- **Basic flow:** reset, dispatch ALU uop (ctrl=5'b00101, rs1=3, rs2=4, both rdy), `i_iss_ready`=1 → `o_iss_valid`=1 the next cycle with matching fields; `count` returns to 0.
- **Queue filter / full:** 8 dispatches with unready sources → `o_full`=1 after the 8th. A 9th is ignored. A MEM-coded packet (queue=01) is never accepted.
- **Wakeup:** entry with rs1=5 not ready; `i_wk_en`=1, `i_wk_tag`=5 at cycle N → issues in cycle N+1.
  - Also: `i_wk_tag`=0 wakes nothing.
  - Also: a wakeup in the same cycle as that entry's dispatch sets r1.
- **Priority/age:** ready entries at slots 0 (pry 00), 1 (pry 11), 2 (pry 00) → issue order 1, 0, 2. The survivors remain compacted.
- **Kill:** entries with brmask 3, 4, 4, 5; kill_tag=4 → `count`=1 and `o_iss_valid`=0 that cycle. Repeat with tags 62, 63, 0, kill_tag=63 → only 62 survives.
- **Async reset mid-run:** assert `i_rst_n` low between edges with 4 entries → `o_iss_valid`/`o_full`=0 immediately; no issue after release.
